// File: rtl/riscv_defines.sv
// Shared RV32 core definitions: pipeline-control state encoding, register and
// instruction constants used by the front-end pipeline registers.
package riscv_defines;

    typedef enum logic [0:0] {
        CTRL_RUN   = 1'b0,
        CTRL_GRANT = 1'b1
    } ctrl_state_e;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/pipe_ctrl_if.sv
// Freeze handshake between an external bus master (debug/DMA) and pipe_ctrl.
interface pipe_ctrl_if;

    logic bus_req_i;
    logic bus_gnt_o;

    modport master (output bus_req_i, input  bus_gnt_o);
    modport slave  (input  bus_req_i, output bus_gnt_o);

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the load in EX and the operands read in ID.
module hazard_detect
    import riscv_defines::*;
(
    input  logic       ex_load_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    output logic       lu_o
);

    always_comb begin
        lu_o = ex_load_i && (ex_rd_addr_i != REG_ZERO) &&
               ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// IF/ID/EX front-end sequencer: jump redirect/flush, load-use bubble, bus-master
// freeze handshake, stall/flush performance counters and a hold-timeout flag.
module pipe_ctrl
    import riscv_defines::*;
#(
    parameter int HOLD_MAX = 1024,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_ctrl_if.slave        bus,
    input  logic              jump_en_i,
    input  logic [31:0]       jump_addr_i,
    input  logic              ex_load_i,
    input  logic [4:0]        ex_rd_addr_i,
    input  logic [4:0]        id_rs1_addr_i,
    input  logic [4:0]        id_rs2_addr_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    output logic              pc_load_o,
    output logic [31:0]       pc_load_addr_o,
    output logic              hold_pc_o,
    output logic              hold_if_id_o,
    output logic              hold_id_ex_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic              hold_timeout_o
);

    localparam int              HC_W      = $clog2(HOLD_MAX + 1);
    localparam logic [HC_W-1:0] HOLD_SAT  = HC_W'(HOLD_MAX);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_MAX - 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;
    logic             lu;

    hazard_detect u_hazard_detect (
        .ex_load_i     (ex_load_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .lu_o          (lu)
    );

    always_comb begin
        state_d        = state_q;
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        hold_cnt_d     = hold_cnt_q;
        timeout_d      = timeout_q;
        pc_load_o      = 1'b0;
        pc_load_addr_o = '0;
        hold_pc_o      = 1'b0;
        hold_if_id_o   = 1'b0;
        hold_id_ex_o   = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;

        // Everything stays quiet while reset is held.
        if (!rst) begin
            if (state_q == CTRL_RUN) begin
                hold_cnt_d = '0;
                if (jump_en_i) begin
                    // A coincident load-use is moot: the hazarding instruction is flushed.
                    pc_load_o      = 1'b1;
                    pc_load_addr_o = jump_addr_i;
                    flush_if_id_o  = 1'b1;
                    flush_id_ex_o  = 1'b1;
                    flush_cnt_d    = flush_cnt_q + CNT_W'(1);
                end else if (lu) begin
                    hold_pc_o     = 1'b1;
                    hold_if_id_o  = 1'b1;
                    flush_id_ex_o = 1'b1;
                    stall_cnt_d   = stall_cnt_q + CNT_W'(1);
                end else if (bus.bus_req_i) begin
                    state_d = CTRL_GRANT;
                end
            end else begin
                hold_pc_o    = 1'b1;
                hold_if_id_o = 1'b1;
                hold_id_ex_o = 1'b1;
                if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
                // This GRANT cycle brings the count to HOLD_MAX; the grant itself stays.
                if (hold_cnt_q >= HOLD_LAST) begin
                    timeout_d = 1'b1;
                end
                if (!bus.bus_req_i) begin
                    state_d    = CTRL_RUN;
                    hold_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CTRL_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.bus_gnt_o  = (state_q == CTRL_GRANT);
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;
    assign hold_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (HOLD_MAX=4, CNT_W=4): jump, load-use, handshake,
// hold timeout, counter wrap and reset-in-grant scenarios.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ex_load_i;
    logic [4:0]  ex_rd_addr_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic        pc_load_o;
    logic [31:0] pc_load_addr_o;
    logic        hold_pc_o;
    logic        hold_if_id_o;
    logic        hold_id_ex_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic [3:0]  stall_cnt_o;
    logic [3:0]  flush_cnt_o;
    logic        hold_timeout_o;

    int errors = 0;
    int checks = 0;

    pipe_ctrl_if bus_if ();

    pipe_ctrl #(.HOLD_MAX(4), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus_if),
        .jump_en_i      (jump_en_i),
        .jump_addr_i    (jump_addr_i),
        .ex_load_i      (ex_load_i),
        .ex_rd_addr_i   (ex_rd_addr_i),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .id_rs1_used_i  (id_rs1_used_i),
        .id_rs2_used_i  (id_rs2_used_i),
        .pc_load_o      (pc_load_o),
        .pc_load_addr_o (pc_load_addr_o),
        .hold_pc_o      (hold_pc_o),
        .hold_if_id_o   (hold_if_id_o),
        .hold_id_ex_o   (hold_id_ex_o),
        .flush_if_id_o  (flush_if_id_o),
        .flush_id_ex_o  (flush_id_ex_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .hold_timeout_o (hold_timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle();
        jump_en_i        = 1'b0;
        jump_addr_i      = 32'h0;
        ex_load_i        = 1'b0;
        ex_rd_addr_i     = 5'd0;
        id_rs1_addr_i    = 5'd0;
        id_rs2_addr_i    = 5'd0;
        id_rs1_used_i    = 1'b0;
        id_rs2_used_i    = 1'b0;
        bus_if.bus_req_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0200;
        ex_load_i = 1'b1; ex_rd_addr_i = 5'd3; id_rs1_addr_i = 5'd3; id_rs1_used_i = 1'b1;
        #1;
        checks++; if (pc_load_o !== 1'b0) begin errors++; $display("FAIL rst_pc_load: got %0b want 0", pc_load_o); end
        checks++; if (pc_load_addr_o !== 32'h0) begin errors++; $display("FAIL rst_pc_addr: got %h want 0", pc_load_addr_o); end
        checks++; if ({hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o} !== 5'b0) begin
            errors++; $display("FAIL rst_ctrl_outs: got %b want 00000", {hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o}); end
        @(negedge clk);
        checks++; if (bus_if.bus_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %0b want 0", bus_if.bus_gnt_o); end
        checks++; if (stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) begin
            errors++; $display("FAIL rst_counters: got stall=%0d flush=%0d want 0/0", stall_cnt_o, flush_cnt_o); end
        checks++; if (hold_timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %0b want 0", hold_timeout_o); end
        idle();
        rst = 1'b0;
    endtask

    task automatic test_jump();
        @(negedge clk);
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0100;
        #1;
        checks++; if (pc_load_o !== 1'b1) begin errors++; $display("FAIL jump_pc_load: got %0b want 1", pc_load_o); end
        checks++; if (pc_load_addr_o !== 32'h0000_0100) begin errors++; $display("FAIL jump_addr: got %h want 00000100", pc_load_addr_o); end
        checks++; if (flush_if_id_o !== 1'b1 || flush_id_ex_o !== 1'b1) begin
            errors++; $display("FAIL jump_flush: got if_id=%0b id_ex=%0b want 1/1", flush_if_id_o, flush_id_ex_o); end
        checks++; if (hold_pc_o !== 1'b0) begin errors++; $display("FAIL jump_hold_pc: got %0b want 0", hold_pc_o); end
        @(negedge clk);
        idle();
        checks++; if (flush_cnt_o !== 4'd1) begin errors++; $display("FAIL jump_flush_cnt: got %0d want 1", flush_cnt_o); end
        #1;
        checks++; if (pc_load_o !== 1'b0 || pc_load_addr_o !== 32'h0) begin
            errors++; $display("FAIL jump_release: got load=%0b addr=%h want 0/0", pc_load_o, pc_load_addr_o); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        ex_load_i = 1'b1; ex_rd_addr_i = 5'd5; id_rs2_addr_i = 5'd5; id_rs2_used_i = 1'b1;
        #1;
        checks++; if ({hold_pc_o, hold_if_id_o, flush_id_ex_o} !== 3'b111) begin
            errors++; $display("FAIL lu_rs2_stall: got %b want 111", {hold_pc_o, hold_if_id_o, flush_id_ex_o}); end
        checks++; if (flush_if_id_o !== 1'b0 || hold_id_ex_o !== 1'b0 || pc_load_o !== 1'b0) begin
            errors++; $display("FAIL lu_rs2_other: got flush_if_id=%0b hold_id_ex=%0b pc_load=%0b want 0/0/0", flush_if_id_o, hold_id_ex_o, pc_load_o); end
        @(negedge clk);
        idle();
        checks++; if (stall_cnt_o !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt_o); end
        #1;
        checks++; if (hold_pc_o !== 1'b0 || flush_id_ex_o !== 1'b0) begin
            errors++; $display("FAIL lu_one_cycle: got hold_pc=%0b flush_id_ex=%0b want 0/0", hold_pc_o, flush_id_ex_o); end
        @(negedge clk);
        ex_load_i = 1'b1; ex_rd_addr_i = 5'd0; id_rs2_addr_i = 5'd0; id_rs2_used_i = 1'b1;
        #1;
        checks++; if (hold_pc_o !== 1'b0 || flush_id_ex_o !== 1'b0) begin
            errors++; $display("FAIL lu_x0: got hold_pc=%0b flush_id_ex=%0b want 0/0", hold_pc_o, flush_id_ex_o); end
        @(negedge clk);
        checks++; if (stall_cnt_o !== 4'd1) begin errors++; $display("FAIL lu_x0_cnt: got %0d want 1", stall_cnt_o); end
        idle();
        ex_load_i = 1'b1; ex_rd_addr_i = 5'd7; id_rs1_addr_i = 5'd7; id_rs1_used_i = 1'b0;
        #1;
        checks++; if (hold_pc_o !== 1'b0) begin errors++; $display("FAIL lu_rs1_unused: got %0b want 0", hold_pc_o); end
        id_rs1_used_i = 1'b1;
        #1;
        checks++; if (hold_pc_o !== 1'b1 || hold_if_id_o !== 1'b1) begin
            errors++; $display("FAIL lu_rs1_stall: got hold_pc=%0b hold_if_id=%0b want 1/1", hold_pc_o, hold_if_id_o); end
        @(negedge clk);
        idle();
        checks++; if (stall_cnt_o !== 4'd2) begin errors++; $display("FAIL lu_rs1_cnt: got %0d want 2", stall_cnt_o); end
    endtask

    task automatic test_jump_lu();
        @(negedge clk);
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0400;
        ex_load_i = 1'b1; ex_rd_addr_i = 5'd9; id_rs1_addr_i = 5'd9; id_rs1_used_i = 1'b1;
        #1;
        checks++; if ({pc_load_o, flush_if_id_o, flush_id_ex_o} !== 3'b111 || {hold_pc_o, hold_if_id_o} !== 2'b00) begin
            errors++; $display("FAIL jlu_outs: got load/fif/fex=%b holds=%b want 111/00", {pc_load_o, flush_if_id_o, flush_id_ex_o}, {hold_pc_o, hold_if_id_o}); end
        @(negedge clk);
        idle();
        checks++; if (flush_cnt_o !== 4'd2 || stall_cnt_o !== 4'd2) begin
            errors++; $display("FAIL jlu_counters: got flush=%0d stall=%0d want 2/2", flush_cnt_o, stall_cnt_o); end
    endtask

    task automatic test_bus_handshake();
        @(negedge clk);
        bus_if.bus_req_i = 1'b1;
        #1;
        checks++; if (bus_if.bus_gnt_o !== 1'b0 || hold_pc_o !== 1'b0) begin
            errors++; $display("FAIL hs_req_cycle: got gnt=%0b hold_pc=%0b want 0/0", bus_if.bus_gnt_o, hold_pc_o); end
        @(negedge clk);
        checks++; if (bus_if.bus_gnt_o !== 1'b1) begin errors++; $display("FAIL hs_gnt_rise: got %0b want 1", bus_if.bus_gnt_o); end
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0800;
        ex_load_i = 1'b1; ex_rd_addr_i = 5'd4; id_rs2_addr_i = 5'd4; id_rs2_used_i = 1'b1;
        #1;
        checks++; if ({hold_pc_o, hold_if_id_o, hold_id_ex_o} !== 3'b111) begin
            errors++; $display("FAIL hs_holds: got %b want 111", {hold_pc_o, hold_if_id_o, hold_id_ex_o}); end
        checks++; if ({pc_load_o, flush_if_id_o, flush_id_ex_o} !== 3'b000 || pc_load_addr_o !== 32'h0) begin
            errors++; $display("FAIL hs_frozen: got load/fif/fex=%b addr=%h want 000/0", {pc_load_o, flush_if_id_o, flush_id_ex_o}, pc_load_addr_o); end
        repeat (3) @(negedge clk);
        jump_en_i = 1'b0; ex_load_i = 1'b0;
        checks++; if (bus_if.bus_gnt_o !== 1'b1) begin errors++; $display("FAIL hs_gnt_held: got %0b want 1", bus_if.bus_gnt_o); end
        bus_if.bus_req_i = 1'b0;
        #1;
        checks++; if (hold_id_ex_o !== 1'b1) begin errors++; $display("FAIL hs_drop_cycle: got hold_id_ex=%0b want 1", hold_id_ex_o); end
        @(negedge clk);
        checks++; if (bus_if.bus_gnt_o !== 1'b0) begin errors++; $display("FAIL hs_gnt_fall: got %0b want 0", bus_if.bus_gnt_o); end
        #1;
        checks++; if ({hold_pc_o, hold_if_id_o, hold_id_ex_o} !== 3'b000) begin
            errors++; $display("FAIL hs_resume: got %b want 000", {hold_pc_o, hold_if_id_o, hold_id_ex_o}); end
        checks++; if (flush_cnt_o !== 4'd2 || stall_cnt_o !== 4'd2) begin
            errors++; $display("FAIL hs_counters: got flush=%0d stall=%0d want 2/2", flush_cnt_o, stall_cnt_o); end
    endtask

    task automatic test_req_with_jump();
        @(negedge clk);
        bus_if.bus_req_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h0000_0040;
        #1;
        checks++; if (pc_load_o !== 1'b1 || pc_load_addr_o !== 32'h0000_0040) begin
            errors++; $display("FAIL rj_jump: got load=%0b addr=%h want 1/00000040", pc_load_o, pc_load_addr_o); end
        @(negedge clk);
        jump_en_i = 1'b0;
        checks++; if (bus_if.bus_gnt_o !== 1'b0) begin errors++; $display("FAIL rj_gnt_wait: got %0b want 0", bus_if.bus_gnt_o); end
        @(negedge clk);
        checks++; if (bus_if.bus_gnt_o !== 1'b1) begin errors++; $display("FAIL rj_gnt_late: got %0b want 1", bus_if.bus_gnt_o); end
        bus_if.bus_req_i = 1'b0;
        @(negedge clk);
        checks++; if (bus_if.bus_gnt_o !== 1'b0 || flush_cnt_o !== 4'd3) begin
            errors++; $display("FAIL rj_release: got gnt=%0b flush=%0d want 0/3", bus_if.bus_gnt_o, flush_cnt_o); end
        // Request raised during a stall, then dropped before it could be granted.
        bus_if.bus_req_i = 1'b1;
        ex_load_i = 1'b1; ex_rd_addr_i = 5'd6; id_rs1_addr_i = 5'd6; id_rs1_used_i = 1'b1;
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++; if (bus_if.bus_gnt_o !== 1'b0 || stall_cnt_o !== 4'd3) begin
            errors++; $display("FAIL abort_req: got gnt=%0b stall=%0d want 0/3", bus_if.bus_gnt_o, stall_cnt_o); end
    endtask

    task automatic test_timeout();
        // Two 3-cycle grants: the hold counter restarts, so no timeout.
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            bus_if.bus_req_i = 1'b1;
            repeat (3) @(negedge clk);
            bus_if.bus_req_i = 1'b0;
        end
        @(negedge clk);
        checks++; if (hold_timeout_o !== 1'b0 || bus_if.bus_gnt_o !== 1'b0) begin
            errors++; $display("FAIL to_short_grants: got timeout=%0b gnt=%0b want 0/0", hold_timeout_o, bus_if.bus_gnt_o); end
        bus_if.bus_req_i = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            checks++; if (hold_timeout_o !== (i >= 5)) begin
                errors++; $display("FAIL to_flag_c%0d: got %0b want %0b", i, hold_timeout_o, (i >= 5)); end
            checks++; if (bus_if.bus_gnt_o !== (i <= 10)) begin
                errors++; $display("FAIL to_gnt_c%0d: got %0b want %0b", i, bus_if.bus_gnt_o, (i <= 10)); end
            if (i == 10) bus_if.bus_req_i = 1'b0;
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_1000;
        repeat (15) @(negedge clk);
        checks++; if (flush_cnt_o !== 4'd15) begin errors++; $display("FAIL wrap_flush_15: got %0d want 15", flush_cnt_o); end
        @(negedge clk);
        idle();
        checks++; if (flush_cnt_o !== 4'd0) begin errors++; $display("FAIL wrap_flush_0: got %0d want 0", flush_cnt_o); end
        ex_load_i = 1'b1; ex_rd_addr_i = 5'd31; id_rs2_addr_i = 5'd31; id_rs2_used_i = 1'b1;
        repeat (3) @(negedge clk);
        idle();
        checks++; if (stall_cnt_o !== 4'd3) begin errors++; $display("FAIL b2b_stall: got %0d want 3", stall_cnt_o); end
    endtask

    task automatic test_reset_in_grant();
        @(negedge clk);
        bus_if.bus_req_i = 1'b1;
        @(negedge clk);
        checks++; if (bus_if.bus_gnt_o !== 1'b1) begin errors++; $display("FAIL rg_gnt: got %0b want 1", bus_if.bus_gnt_o); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_if.bus_req_i = 1'b0;
        checks++; if (bus_if.bus_gnt_o !== 1'b0) begin errors++; $display("FAIL rg_gnt_fall: got %0b want 0", bus_if.bus_gnt_o); end
        checks++; if (stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0 || hold_timeout_o !== 1'b0) begin
            errors++; $display("FAIL rg_clear: got stall=%0d flush=%0d timeout=%0b want 0/0/0", stall_cnt_o, flush_cnt_o, hold_timeout_o); end
        #1;
        checks++; if ({hold_pc_o, hold_if_id_o, hold_id_ex_o} !== 3'b000) begin
            errors++; $display("FAIL rg_holds: got %b want 000", {hold_pc_o, hold_if_id_o, hold_id_ex_o}); end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_jump();
        test_load_use();
        test_jump_lu();
        test_bus_handshake();
        test_req_with_jump();
        test_reset();
        test_timeout();
        checks++; if (hold_timeout_o !== 1'b1) begin errors++; $display("FAIL to_sticky: got %0b want 1", hold_timeout_o); end
        test_reset();
        test_wrap();
        test_reset_in_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
